// File: rtl/shift_seq_gen_pkg.sv
// Shared definitions for the shift-register sequence generator.
// Holds the mode encodings and the start state that each mode's sequence
// begins from and returns to. The period measurement and the wrap pulse
// both depend on that start state.
package shift_seq_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_RING     = 2'd0;
   localparam mode_t MODE_JOHNSON  = 2'd1;
   localparam mode_t MODE_LFSR     = 2'd2;
   localparam mode_t MODE_DEBRUIJN = 2'd3;

   // Start state for a mode, masked to the active register width.
   // Ring and LFSR start at 0..01, because the all-zero state is illegal for them.
   // Johnson and de Bruijn start at 0..0.
   function automatic logic [15:0] start_state(input mode_t mode, input int width);
      logic [15:0] mask;
      mask = 16'hFFFF >> (16 - width);
      if (mode == MODE_RING || mode == MODE_LFSR) begin
         start_state = 16'h0001 & mask;
      end else begin
         start_state = 16'h0000;
      end
   endfunction

endpackage

// File: rtl/shift_seq_gen_if.sv
// Control and status bundle for shift_seq_gen.
//   en, mode, load, load_val : driven by the master (the controller)
//   q, wrap, period, period_vld : driven by the slave (the generator)
// The slave modport is used as the generator's port. The master modport is
// used by whatever drives the generator.
interface shift_seq_gen_if
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 4
) ();

   logic             en;
   mode_t            mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic             wrap;
   logic [WIDTH:0]   period;
   logic             period_vld;

   modport master (
      output en, mode, load, load_val,
      input  q, wrap, period, period_vld
   );

   modport slave (
      input  en, mode, load, load_val,
      output q, wrap, period, period_vld
   );

endinterface

// File: rtl/shift_seq_gen_next.sv
// Next-state logic for the shift register. This block is purely combinational.
//   q      : current register state
//   mode   : feedback mode to shift with
//   q_next : state after one shift, with illegal-state correction applied
// The correction takes the place of the normal shift. This pulls a ring or
// Johnson register that holds an illegal pattern back onto its cycle. It also
// lifts an LFSR out of the all-zero lock-up state.
module shift_seq_next
   import shift_seq_pkg::*;
#(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = 'b1100
) (
   input  logic [WIDTH-1:0] q,
   input  mode_t            mode,
   output logic [WIDTH-1:0] q_next
);

   localparam logic [WIDTH-1:0] ONE_Q = 1;
   localparam logic [WIDTH-2:0] ONE_T = 1;

   logic [WIDTH-2:0] trans;
   logic             lfsr_fb;
   logic             ring_bad;
   logic             johnson_bad;

   // A bit is set in trans for each adjacent pair of bits that differ.
   // A legal Johnson state has at most one such pair. x & (x-1) clears the
   // lowest set bit, so a nonzero result means x had two or more bits set.
   always_comb begin
      trans       = q[WIDTH-2:0] ^ q[WIDTH-1:1];
      lfsr_fb     = ^(q & TAPS);
      ring_bad    = (q == '0) || ((q & (q - ONE_Q)) != '0);
      johnson_bad = (trans & (trans - ONE_T)) != '0;
   end

   // De Bruijn adds one extra term to the LFSR feedback. The term inverts the
   // feedback when the low bits are all zero. This splices 0..0 into the
   // cycle between 10..0 and 0..01.
   always_comb begin
      q_next = q;
      unique case (mode)
         MODE_RING: begin
            if (ring_bad) q_next = ONE_Q;
            else          q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         end
         MODE_JOHNSON: begin
            if (johnson_bad) q_next = '0;
            else             q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
         end
         MODE_LFSR: begin
            if (q == '0) q_next = ONE_Q;
            else         q_next = {q[WIDTH-2:0], lfsr_fb};
         end
         default: begin
            q_next = {q[WIDTH-2:0], lfsr_fb ^ (q[WIDTH-2:0] == '0)};
         end
      endcase
   end

endmodule

// File: rtl/shift_seq_gen.sv
// Shift-register sequence generator with ring, Johnson, LFSR and de Bruijn modes.
// It also measures the period of the running sequence.
//   clk   : rising-edge clock
//   rst_n : synchronous reset, active low
//   bus   : slave side of shift_seq_gen_if
//           inputs  en, mode, load, load_val
//           outputs q, wrap, period, period_vld
// The count restarts on a load, on a mode change and on reset. A new period
// is published only after a complete cycle through the start state.
module shift_seq_gen
   import shift_seq_pkg::*;
#(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = 'b1100
) (
   input  logic            clk,
   input  logic            rst_n,
   shift_seq_gen_if.slave  bus
);

   localparam logic [WIDTH-1:0] Q_RST   = 1;
   localparam logic [WIDTH:0]   CNT_ONE = 1;

   logic [WIDTH-1:0] q_q, q_d, q_next, start_val;
   mode_t            mode_q, mode_d;
   logic [WIDTH:0]   cnt_q, cnt_d;
   logic [WIDTH:0]   period_q, period_d;
   logic             wrap_q, wrap_d;
   logic             period_vld_q, period_vld_d;

   shift_seq_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_next (
      .q      (q_q),
      .mode   (bus.mode),
      .q_next (q_next)
   );

   // Load has priority. A mode change in the same cycle restarts the count,
   // but the shift still uses the new feedback, so the register keeps moving.
   always_comb begin
      start_val    = WIDTH'(start_state(bus.mode, WIDTH));
      q_d          = q_q;
      mode_d       = bus.mode;
      cnt_d        = cnt_q;
      period_d     = period_q;
      wrap_d       = 1'b0;
      period_vld_d = period_vld_q;
      if (bus.load) begin
         q_d          = bus.load_val;
         cnt_d        = '0;
         period_vld_d = 1'b0;
      end else if (bus.mode != mode_q) begin
         if (bus.en) q_d = q_next;
         cnt_d        = '0;
         period_vld_d = 1'b0;
      end else if (bus.en) begin
         q_d = q_next;
         if (q_next == start_val) begin
            wrap_d       = 1'b1;
            period_d     = cnt_q + CNT_ONE;
            period_vld_d = 1'b1;
            cnt_d        = '0;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q          <= Q_RST;
         mode_q       <= MODE_RING;
         cnt_q        <= '0;
         period_q     <= '0;
         wrap_q       <= 1'b0;
         period_vld_q <= 1'b0;
      end else begin
         q_q          <= q_d;
         mode_q       <= mode_d;
         cnt_q        <= cnt_d;
         period_q     <= period_d;
         wrap_q       <= wrap_d;
         period_vld_q <= period_vld_d;
      end
   end

   assign bus.q          = q_q;
   assign bus.wrap       = wrap_q;
   assign bus.period     = period_q;
   assign bus.period_vld = period_vld_q;

endmodule

// File: tb/tb_shift_seq_gen.sv
// Directed testbench for shift_seq_gen with WIDTH=4 and TAPS=4'b1100.
// The expected sequences below were worked out by hand from the feedback equations.
module tb_shift_seq_gen;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   logic [3:0] ring_seq    [4]  = '{4'h2, 4'h4, 4'h8, 4'h1};
   logic [3:0] johnson_seq [8]  = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
   logic [3:0] lfsr_seq    [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                                    4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
   logic [3:0] db_seq      [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                                    4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

   shift_seq_gen_if #(.WIDTH(4)) bus ();

   shift_seq_gen #(
      .WIDTH (4),
      .TAPS  (4'b1100)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Drive the inputs, then advance one clock. Outputs are sampled 1 ns after the edge.
   task automatic applyStimulus(input logic e, input logic [1:0] m, input logic l,
                                input logic [3:0] lv);
      bus.en       = e;
      bus.mode     = m;
      bus.load     = l;
      bus.load_val = lv;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b0, 2'd0, 1'b0, 4'h0);
      applyStimulus(1'b0, 2'd0, 1'b0, 4'h0);
      checkOutput("reset q", 32'(bus.q), 32'h1);
      checkOutput("reset wrap", 32'(bus.wrap), 32'h0);
      checkOutput("reset period", 32'(bus.period), 32'h0);
      checkOutput("reset period_vld", 32'(bus.period_vld), 32'h0);

      $display("[TB] ring from reset");
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 2'd0, 1'b0, 4'h0);
         checkOutput($sformatf("ring q[%0d]", i), 32'(bus.q), 32'(ring_seq[i]));
         checkOutput($sformatf("ring wrap[%0d]", i), 32'(bus.wrap), 32'(i == 3));
      end
      checkOutput("ring period", 32'(bus.period), 32'd4);
      checkOutput("ring period_vld", 32'(bus.period_vld), 32'h1);

      $display("[TB] johnson from 0000");
      applyStimulus(1'b0, 2'd1, 1'b1, 4'h0);
      checkOutput("johnson load q", 32'(bus.q), 32'h0);
      checkOutput("johnson load period_vld", 32'(bus.period_vld), 32'h0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 2'd1, 1'b0, 4'h0);
         checkOutput($sformatf("johnson q[%0d]", i), 32'(bus.q), 32'(johnson_seq[i]));
         checkOutput($sformatf("johnson wrap[%0d]", i), 32'(bus.wrap), 32'(i == 7));
      end
      checkOutput("johnson period", 32'(bus.period), 32'd8);
      checkOutput("johnson period_vld", 32'(bus.period_vld), 32'h1);

      $display("[TB] lfsr from 0001");
      applyStimulus(1'b0, 2'd2, 1'b1, 4'h1);
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b1, 2'd2, 1'b0, 4'h0);
         checkOutput($sformatf("lfsr q[%0d]", i), 32'(bus.q), 32'(lfsr_seq[i]));
         checkOutput($sformatf("lfsr wrap[%0d]", i), 32'(bus.wrap), 32'(i == 14));
      end
      checkOutput("lfsr period", 32'(bus.period), 32'd15);
      applyStimulus(1'b0, 2'd2, 1'b1, 4'h0);
      checkOutput("lfsr lockup load q", 32'(bus.q), 32'h0);
      applyStimulus(1'b1, 2'd2, 1'b0, 4'h0);
      checkOutput("lfsr lockup recover q", 32'(bus.q), 32'h1);
      checkOutput("lfsr lockup recover wrap", 32'(bus.wrap), 32'h1);

      $display("[TB] de bruijn from 0000");
      applyStimulus(1'b0, 2'd3, 1'b1, 4'h0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 2'd3, 1'b0, 4'h0);
         checkOutput($sformatf("debruijn q[%0d]", i), 32'(bus.q), 32'(db_seq[i]));
         checkOutput($sformatf("debruijn wrap[%0d]", i), 32'(bus.wrap), 32'(i == 15));
      end
      checkOutput("debruijn period", 32'(bus.period), 32'd16);
      checkOutput("debruijn period_vld", 32'(bus.period_vld), 32'h1);

      $display("[TB] correction of illegal states");
      applyStimulus(1'b0, 2'd0, 1'b1, 4'h5);
      checkOutput("ring illegal load q", 32'(bus.q), 32'h5);
      checkOutput("ring illegal load period_vld", 32'(bus.period_vld), 32'h0);
      applyStimulus(1'b1, 2'd0, 1'b0, 4'h0);
      checkOutput("ring corrected q", 32'(bus.q), 32'h1);
      checkOutput("ring corrected wrap", 32'(bus.wrap), 32'h1);
      applyStimulus(1'b0, 2'd1, 1'b1, 4'h5);
      checkOutput("johnson illegal load q", 32'(bus.q), 32'h5);
      applyStimulus(1'b1, 2'd1, 1'b0, 4'h0);
      checkOutput("johnson corrected q", 32'(bus.q), 32'h0);
      checkOutput("johnson corrected wrap", 32'(bus.wrap), 32'h1);

      $display("[TB] mode change and mid-run reset");
      applyStimulus(1'b0, 2'd0, 1'b1, 4'h1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd0, 1'b0, 4'h0);
      checkOutput("pre-change period_vld", 32'(bus.period_vld), 32'h1);
      checkOutput("pre-change period", 32'(bus.period), 32'd4);
      applyStimulus(1'b1, 2'd2, 1'b0, 4'h0);
      checkOutput("mode change period_vld", 32'(bus.period_vld), 32'h0);
      checkOutput("mode change q", 32'(bus.q), 32'h2);
      applyStimulus(1'b1, 2'd2, 1'b0, 4'h0);
      checkOutput("after change q", 32'(bus.q), 32'h4);
      rst_n = 1'b0;
      applyStimulus(1'b1, 2'd2, 1'b1, 4'hA);
      checkOutput("mid reset q", 32'(bus.q), 32'h1);
      checkOutput("mid reset wrap", 32'(bus.wrap), 32'h0);
      checkOutput("mid reset period", 32'(bus.period), 32'h0);
      checkOutput("mid reset period_vld", 32'(bus.period_vld), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
